// File: rtl/cpu_pkg.sv
// Shared encodings for the sequencer: instruction classes, ALU function and B-mux selects,
// the FSM state type and the control bundle produced by the decoder.
package cpu_pkg;

  localparam int unsigned CLASS_W = 4;
  localparam int unsigned F_W     = 3;
  localparam int unsigned BSEL_W  = 2;

  typedef enum logic [CLASS_W-1:0] {
    CLS_NOP  = 4'b0000,
    CLS_JMP  = 4'b0001,
    CLS_JC   = 4'b0010,
    CLS_JZ   = 4'b0011,
    CLS_LDI  = 4'b0100,
    CLS_IO   = 4'b0101,
    CLS_MOV  = 4'b0110,
    CLS_ALU4 = 4'b1010,
    CLS_ALU5 = 4'b1011,
    CLS_ALU6 = 4'b1100,
    CLS_ALU7 = 4'b1101,
    CLS_HALT = 4'b1111
  } class_e;

  localparam logic [F_W-1:0] F_PASS_A = 3'b000;
  localparam logic [F_W-1:0] F_PASS_B = 3'b001;
  localparam logic [F_W-1:0] F_OP4    = 3'b100;
  localparam logic [F_W-1:0] F_OP5    = 3'b101;
  localparam logic [F_W-1:0] F_OP6    = 3'b110;
  localparam logic [F_W-1:0] F_OP7    = 3'b111;

  localparam logic [BSEL_W-1:0] BSEL_REG = 2'b00;
  localparam logic [BSEL_W-1:0] BSEL_IMM = 2'b01;
  localparam logic [BSEL_W-1:0] BSEL_IN  = 2'b11;

  typedef enum logic [1:0] {
    ST_FETCH = 2'b00,
    ST_EXEC  = 2'b01,
    ST_HALT  = 2'b10
  } state_e;

  typedef struct packed {
    logic [F_W-1:0]    f;
    logic [BSEL_W-1:0] b_sel;
    logic              write_a;
    logic              write_b;
    logic              write_o;
    logic              write_cz;
    logic              pc_sel;
    logic              write_pc;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '0;

  // Plain PC advance; also what every undefined encoding executes as.
  function automatic ctrl_t ctrl_nop();
    ctrl_t c;
    c          = CTRL_IDLE;
    c.write_pc = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/cu_decode.sv
// Combinational instruction decoder: latched instruction plus ALU flags to a control bundle,
// with flags for undefined encodings and the HALT instruction.
module cu_decode
  import cpu_pkg::*;
#(
  parameter int unsigned OPCODE_W = 8
) (
  input  logic [OPCODE_W-1:0] instr,
  input  logic                carry,
  input  logic                zero,
  output ctrl_t               ctrl,
  output logic                illegal,
  output logic                is_halt
);

  localparam int unsigned EXT_W = OPCODE_W - CLASS_W;

  class_e           cls;
  logic [EXT_W-1:0] ext;
  logic             ext_zero;

  assign cls      = class_e'(instr[OPCODE_W-1 -: CLASS_W]);
  assign ext      = instr[EXT_W-1:0];
  assign ext_zero = (ext == EXT_W'(0));

  always_comb begin
    ctrl    = CTRL_IDLE;
    illegal = 1'b0;
    is_halt = 1'b0;
    unique case (cls)
      CLS_NOP: ctrl = ctrl_nop();
      CLS_JMP, CLS_JC, CLS_JZ: begin
        ctrl.f        = F_PASS_B;
        ctrl.b_sel    = BSEL_IMM;
        ctrl.write_pc = 1'b1;
        ctrl.write_cz = (cls == CLS_JMP);
        ctrl.pc_sel   = (cls == CLS_JMP) | ((cls == CLS_JC) & carry) | ((cls == CLS_JZ) & zero);
      end
      CLS_LDI: begin
        ctrl.f        = F_PASS_B;
        ctrl.b_sel    = BSEL_IMM;
        ctrl.write_a  = 1'b1;
        ctrl.write_cz = 1'b1;
        ctrl.write_pc = 1'b1;
      end
      CLS_IO: begin
        if (ext_zero) begin
          ctrl.f        = F_PASS_B;
          ctrl.b_sel    = BSEL_IN;
          ctrl.write_a  = 1'b1;
          ctrl.write_cz = 1'b1;
          ctrl.write_pc = 1'b1;
        end else if (ext == EXT_W'(1)) begin
          ctrl.f        = F_PASS_A;
          ctrl.write_o  = 1'b1;
          ctrl.write_cz = 1'b1;
          ctrl.write_pc = 1'b1;
        end else begin
          ctrl    = ctrl_nop();
          illegal = 1'b1;
        end
      end
      CLS_MOV: begin
        if (ext_zero) begin
          ctrl.f        = F_PASS_A;
          ctrl.write_b  = 1'b1;
          ctrl.write_cz = 1'b1;
          ctrl.write_pc = 1'b1;
        end else begin
          ctrl    = ctrl_nop();
          illegal = 1'b1;
        end
      end
      CLS_ALU4, CLS_ALU5, CLS_ALU6, CLS_ALU7: begin
        if (ext_zero) begin
          case (cls)
            CLS_ALU4: ctrl.f = F_OP4;
            CLS_ALU5: ctrl.f = F_OP5;
            CLS_ALU6: ctrl.f = F_OP6;
            default:  ctrl.f = F_OP7;
          endcase
          ctrl.b_sel    = BSEL_REG;
          ctrl.write_a  = 1'b1;
          ctrl.write_cz = 1'b1;
          ctrl.write_pc = 1'b1;
        end else begin
          ctrl    = ctrl_nop();
          illegal = 1'b1;
        end
      end
      CLS_HALT: begin
        if (ext_zero) begin
          is_halt = 1'b1;
        end else begin
          ctrl    = ctrl_nop();
          illegal = 1'b1;
        end
      end
      default: begin
        ctrl    = ctrl_nop();
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/seq_control_unit.sv
// Two-cycle fetch/execute sequencer with HALT, sticky illegal-instruction flag and a
// saturating retired-instruction counter.
module seq_control_unit
  import cpu_pkg::*;
#(
  parameter int unsigned OPCODE_W = 8,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                instr_valid,
  output logic                instr_ready,
  input  logic                carry,
  input  logic                zero,
  input  logic                resume,
  output logic [2:0]          f,
  output logic [1:0]          b_sel,
  output logic                write_a,
  output logic                write_b,
  output logic                write_o,
  output logic                write_cz,
  output logic                pc_sel,
  output logic                write_pc,
  output logic                halted,
  output logic                illegal_op,
  output logic [CNT_W-1:0]    instr_count
);

  state_e              state;
  state_e              state_nxt;
  logic [OPCODE_W-1:0] ir;
  ctrl_t               dec_ctrl;
  ctrl_t               ctrl;
  logic                dec_illegal;
  logic                dec_halt;
  logic                accept;
  logic                exec;

  assign accept = (state == ST_FETCH) & instr_valid;
  assign exec   = (state == ST_EXEC);

  cu_decode #(.OPCODE_W(OPCODE_W)) u_decode (
    .instr   (ir),
    .carry   (carry),
    .zero    (zero),
    .ctrl    (dec_ctrl),
    .illegal (dec_illegal),
    .is_halt (dec_halt)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_FETCH;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_FETCH: if (instr_valid) state_nxt = ST_EXEC;
      ST_EXEC:  state_nxt = dec_halt ? ST_HALT : ST_FETCH;
      ST_HALT:  if (resume) state_nxt = ST_FETCH;
      default:  state_nxt = ST_FETCH;
    endcase
  end

  // Outputs: strobes only in EXEC, decoded from the latched instruction and live flags.
  always_comb begin
    ctrl        = CTRL_IDLE;
    instr_ready = 1'b0;
    halted      = 1'b0;
    unique case (state)
      ST_FETCH: instr_ready = 1'b1;
      ST_EXEC:  ctrl = dec_ctrl;
      ST_HALT:  halted = 1'b1;
      default:  instr_ready = 1'b0;
    endcase
  end

  assign f        = ctrl.f;
  assign b_sel    = ctrl.b_sel;
  assign write_a  = ctrl.write_a;
  assign write_b  = ctrl.write_b;
  assign write_o  = ctrl.write_o;
  assign write_cz = ctrl.write_cz;
  assign pc_sel   = ctrl.pc_sel;
  assign write_pc = ctrl.write_pc;

  // Instruction register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      ir <= '0;
    else if (accept) ir <= opcode;
  end

  // Retirement bookkeeping at the edge that ends each EXEC cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_count <= '0;
      illegal_op  <= 1'b0;
    end else if (exec) begin
      if (~&instr_count) instr_count <= instr_count + CNT_W'(1);
      if (dec_illegal)   illegal_op  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_seq_control_unit.sv
// Randomized and directed bench for seq_control_unit against an instruction-level model;
// a second instance with a 2-bit counter exercises saturation.
module tb_seq_control_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] opcode;
  logic       instr_valid, carry, zero, resume;

  logic       instr_ready, write_a, write_b, write_o, write_cz, pc_sel, write_pc, halted, illegal_op;
  logic [2:0] f;
  logic [1:0] b_sel;
  logic [15:0] instr_count;

  logic       instr_ready2, write_a2, write_b2, write_o2, write_cz2, pc_sel2, write_pc2, halted2, illegal_op2;
  logic [2:0] f2;
  logic [1:0] b_sel2;
  logic [1:0] instr_count2;

  int checks = 0;
  int failures = 0;

  // Model of the instruction-level behaviour.
  int         m_phase;   // 0 waiting for instruction, 1 executing, 2 halted
  logic [7:0] m_instr;
  int         m_count;
  logic       m_illegal;

  always #5 clk = ~clk;

  seq_control_unit #(.OPCODE_W(8), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .carry(carry), .zero(zero), .resume(resume), .f(f), .b_sel(b_sel), .write_a(write_a),
    .write_b(write_b), .write_o(write_o), .write_cz(write_cz), .pc_sel(pc_sel), .write_pc(write_pc),
    .halted(halted), .illegal_op(illegal_op), .instr_count(instr_count)
  );

  seq_control_unit #(.OPCODE_W(8), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .instr_valid(instr_valid), .instr_ready(instr_ready2),
    .carry(carry), .zero(zero), .resume(resume), .f(f2), .b_sel(b_sel2), .write_a(write_a2),
    .write_b(write_b2), .write_o(write_o2), .write_cz(write_cz2), .pc_sel(pc_sel2), .write_pc(write_pc2),
    .halted(halted2), .illegal_op(illegal_op2), .instr_count(instr_count2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // {f, b_sel, write_a, write_b, write_o, write_cz, pc_sel, write_pc}
  function automatic logic [10:0] mk(int fv, int bv, bit a, bit b, bit o, bit cz, bit ps, bit pc);
    return {fv[2:0], bv[1:0], a, b, o, cz, ps, pc};
  endfunction

  function automatic bit is_legal(logic [7:0] op);
    return (op[7:4] <= 4'd4) || op == 8'h50 || op == 8'h51 || op == 8'h60 ||
           op == 8'hA0 || op == 8'hB0 || op == 8'hC0 || op == 8'hD0 || op == 8'hF0;
  endfunction

  function automatic logic [10:0] exp_ctrl(logic [7:0] op, logic c, logic z);
    if (!is_legal(op))            return mk(0, 0, 0, 0, 0, 0, 0, 1);
    if (op[7:4] == 4'd0)          return mk(0, 0, 0, 0, 0, 0, 0, 1);
    if (op[7:4] == 4'd1)          return mk(1, 1, 0, 0, 0, 1, 1, 1);
    if (op[7:4] == 4'd2)          return mk(1, 1, 0, 0, 0, 0, c, 1);
    if (op[7:4] == 4'd3)          return mk(1, 1, 0, 0, 0, 0, z, 1);
    if (op[7:4] == 4'd4)          return mk(1, 1, 1, 0, 0, 1, 0, 1);
    if (op == 8'h50)              return mk(1, 3, 1, 0, 0, 1, 0, 1);
    if (op == 8'h51)              return mk(0, 0, 0, 0, 1, 1, 0, 1);
    if (op == 8'h60)              return mk(0, 0, 0, 1, 0, 1, 0, 1);
    if (op == 8'hF0)              return 11'd0;
    return mk(4 + int'(op[7:4]) - 10, 0, 1, 0, 0, 1, 0, 1);
  endfunction

  function automatic logic [10:0] dut_ctrl();
    return {f, b_sel, write_a, write_b, write_o, write_cz, pc_sel, write_pc};
  endfunction

  function automatic logic [10:0] dut2_ctrl();
    return {f2, b_sel2, write_a2, write_b2, write_o2, write_cz2, pc_sel2, write_pc2};
  endfunction

  task automatic model_reset();
    m_phase = 0; m_instr = 8'h00; m_count = 0; m_illegal = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    logic [10:0] ec;
    int c16, c2;
    ec  = (m_phase == 1) ? exp_ctrl(m_instr, carry, zero) : 11'd0;
    c16 = (m_count > 65535) ? 65535 : m_count;
    c2  = (m_count > 3) ? 3 : m_count;
    check({tag, ".ctrl"},    32'(dut_ctrl()), 32'(ec));
    check({tag, ".ready"},   32'(instr_ready), 32'(m_phase == 0));
    check({tag, ".halted"},  32'(halted), 32'(m_phase == 2));
    check({tag, ".illegal"}, 32'(illegal_op), 32'(m_illegal));
    check({tag, ".count"},   32'(instr_count), 32'(c16));
    check({tag, ".ctrl2"},   32'(dut2_ctrl()), 32'(ec));
    check({tag, ".state2"},  32'({instr_ready2, halted2, illegal_op2}),
          32'({m_phase == 0, m_phase == 2, m_illegal}));
    check({tag, ".count2"},  32'(instr_count2), 32'(c2));
  endtask

  // One cycle: drive inputs, check this cycle's outputs, advance model across the edge.
  task automatic step(input string tag, input logic v, input logic [7:0] op,
                      input logic c, input logic z, input logic r);
    instr_valid = v; opcode = op; carry = c; zero = z; resume = r;
    #1;
    check_outputs(tag);
    @(posedge clk);
    if (m_phase == 0) begin
      if (v) begin m_instr = op; m_phase = 1; end
    end else if (m_phase == 1) begin
      m_count++;
      if (!is_legal(m_instr)) m_illegal = 1'b1;
      m_phase = (m_instr == 8'hF0) ? 2 : 0;
    end else if (r) begin
      m_phase = 0;
    end
    #1;
  endtask

  function automatic logic [7:0] rand_op();
    logic [7:0] tbl [13];
    tbl = '{8'h00, 8'h17, 8'h23, 8'h3C, 8'h4F, 8'h50, 8'h51, 8'h60, 8'hA0, 8'hB0, 8'hC0, 8'hD0, 8'hF0};
    if ($urandom_range(3) == 0) return 8'($urandom);
    return tbl[$urandom_range(12)];
  endfunction

  initial begin
    rst_n = 1'b0; instr_valid = 1'b1; opcode = 8'hA0; carry = 1'b0; zero = 1'b0; resume = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    rst_n = 1'b1;

    // ALU op with valid held: strobes one cycle after acceptance.
    step("alu_fetch", 1, 8'hA0, 0, 0, 0);
    check("alu_exec.ctrl", 32'(dut_ctrl()), 32'(mk(4, 0, 1, 0, 0, 1, 0, 1)));
    step("alu_exec", 0, 8'h00, 0, 0, 0);
    check("alu_done.count", 32'(instr_count), 32'd1);
    check("alu_done.ready", 32'(instr_ready), 32'd1);

    // Conditional jumps on carry.
    step("jc0_fetch", 1, 8'h23, 0, 0, 0);
    step("jc0_exec",  0, 8'h00, 0, 1, 0);
    step("jc1_fetch", 1, 8'h23, 0, 0, 0);
    check("jc1_exec.pc_sel", 32'({pc_sel, write_cz}), 32'({1'b0, 1'b0}));
    step("jc1_exec",  0, 8'h00, 1, 0, 0);
    step("jz_fetch",  1, 8'h35, 0, 0, 0);
    step("jz_exec",   0, 8'h00, 0, 1, 0);

    // Illegal opcode, then flag persists.
    step("ill_fetch", 1, 8'hA5, 0, 0, 0);
    step("ill_exec",  0, 8'h00, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step("post_ill_f", 1, 8'h40, 0, 0, 0);
      step("post_ill_e", 0, 8'h00, 0, 0, 0);
    end
    check("ill_sticky", 32'(illegal_op), 32'd1);

    // HALT holds with valid asserted, resume pulse returns to fetch.
    step("halt_fetch", 1, 8'hF0, 0, 0, 0);
    step("halt_exec",  1, 8'h60, 0, 0, 0);
    for (int i = 0; i < 10; i++) step("halt_hold", 1, 8'h60, 0, 0, 0);
    step("halt_resume", 1, 8'h60, 0, 0, 1);
    step("resume_fetch", 1, 8'h60, 0, 0, 0);
    step("resume_exec", 0, 8'h00, 0, 0, 0);

    // Idle source.
    for (int i = 0; i < 5; i++) step("idle", 0, 8'hA0, 1, 1, 1);

    // Reset in the middle of an LDI execution.
    step("rst_fetch", 1, 8'h40, 0, 0, 0);
    check("rst_pre.write_a", 32'(write_a), 32'd1);
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_mid.write_a", 32'(write_a), 32'd0);
    check_outputs("rst_mid");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_outputs("rst_after");

    // Five instructions saturate the 2-bit counter.
    for (int i = 0; i < 5; i++) begin
      step("sat_f", 1, 8'hB0, 0, 0, 0);
      step("sat_e", 0, 8'h00, 0, 0, 0);
    end
    check("sat.count2", 32'(instr_count2), 32'd3);
    check("sat.count", 32'(instr_count), 32'd5);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      step("rand", 1'($urandom_range(3) != 0), rand_op(), 1'($urandom), 1'($urandom),
           1'($urandom_range(3) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
